sr_reg_bank: RTL and testbench

//  Parametrised bank of WIDTH clocked set/reset storage elements, successor to the single-bit SR flop.

---
 rtl/srff_pkg.sv | 50 +++++
 rtl/sr_cell.sv | 35 +++
 rtl/sr_reg_bank.sv | 92 +++++++++
 tb/tb_sr_reg_bank.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/srff_pkg.sv
// Shared types and next-state logic for the set/reset register bank.
//   mode_e     : per-edge update mode (SR / JK / D / T)
//   POL_*      : SR-mode action when s and r are both high
//   srff_next  : single-bit next-state function used by sr_cell
package srff_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;

  function automatic logic srff_next(input logic q, input logic s, input logic r,
                                     input mode_e mode, input int policy);
    logic nq;
    nq = q;
    case (mode)
      MODE_SR: begin
        case ({s, r})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11: begin
            if (policy == POL_SET)      nq = 1'b1;
            else if (policy == POL_RST) nq = 1'b0;
            else                        nq = q;
          end
          default: nq = q;
        endcase
      end
      MODE_JK: begin
        case ({s, r})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11:   nq = ~q;
          default: nq = q;
        endcase
      end
      MODE_D:  nq = s;
      MODE_T:  nq = q ^ s;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One storage channel: combinational next-state from (q, s, r, mode, policy)
// followed by a single flop.
//   clk, rst_n : clock, async active-low reset (loads RESET_BIT)
//   en         : update enable, 0 holds q
//   mode       : update mode for this edge
//   s, r       : set/J/D/T and reset/K inputs
//   q          : stored bit
module sr_cell
  import srff_pkg::*;
#(
  parameter int   POLICY    = POL_HOLD,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  mode_e mode,
  input  logic  s,
  input  logic  r,
  output logic  q
);

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    if (en) q_nxt = srff_next(q, s, r, mode, POLICY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_BIT;
    else        q <= q_nxt;
  end

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH set/reset channels with runtime mode select and registered
// SR-conflict reporting.
//   clk, rst_n      : clock, async active-low reset
//   en              : update enable (also gates conflict detection)
//   mode            : 00 SR, 01 JK, 10 D, 11 T
//   s, r            : per-channel set/J/D/T and reset/K inputs
//   clr_err         : synchronous clear of conflict_cnt / conflict_sticky
//   q, q_n          : stored state and its complement
//   conflict        : pulse, previous edge saw an SR conflict
//   conflict_mask   : bits that collided on that edge
//   conflict_cnt    : saturating count of conflict edges
//   conflict_sticky : set on any conflict edge until cleared
module sr_reg_bank
  import srff_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               CNT_W           = 8,
  parameter int               CONFLICT_POLICY = POL_HOLD,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             conflict,
  output logic [WIDTH-1:0] conflict_mask,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             conflict_sticky
);

  if (CONFLICT_POLICY != POL_HOLD && CONFLICT_POLICY != POL_SET &&
      CONFLICT_POLICY != POL_RST) begin : g_bad_policy
    $error("sr_reg_bank: CONFLICT_POLICY must be 0, 1 or 2");
  end

  mode_e            mode_q;
  logic [WIDTH-1:0] both;
  logic             conflict_edge;

  assign mode_q        = mode_e'(mode);
  assign both          = s & r;
  assign conflict_edge = en && (mode_q == MODE_SR) && (|both);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .POLICY   (CONFLICT_POLICY),
      .RESET_BIT(RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .mode (mode_q),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i])
    );
  end

  assign q_n = ~q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict      <= 1'b0;
      conflict_mask <= '0;
    end else begin
      conflict      <= conflict_edge;
      conflict_mask <= conflict_edge ? both : '0;
    end
  end

  // A conflict on the same edge as clr_err wins: the clear is applied first,
  // then this edge's event is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt    <= '0;
      conflict_sticky <= 1'b0;
    end else if (conflict_edge) begin
      conflict_sticky <= 1'b1;
      if (clr_err)                 conflict_cnt <= CNT_W'(1);
      else if (~&conflict_cnt)     conflict_cnt <= conflict_cnt + CNT_W'(1);
    end else if (clr_err) begin
      conflict_cnt    <= '0;
      conflict_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_reg_bank.sv
module tb_sr_reg_bank;

  // Four instances share stimulus:
  //   u0 policy hold, u1 policy set (RESET_VAL 3C), u2 policy reset, u3 CNT_W=2
  typedef struct packed {
    logic [3:0][7:0] q;
    logic            conflict;
    logic [7:0]      mask;
    logic [3:0][7:0] cnt;
    logic            sticky;
  } exp_t;

  logic       clk, rst_n, en, clr_err;
  logic [1:0] mode;
  logic [7:0] s, r;

  logic [7:0] q0, q1, q2, q3, qn0, qn1, qn2, qn3;
  logic [7:0] mk0, mk1, mk2, mk3;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;
  logic       cf0, cf1, cf2, cf3, st0, st1, st2, st3;

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [7:0] mq[4];
  logic [7:0] mcnt[4];
  logic       mst;

  sr_reg_bank #(.WIDTH(8), .CNT_W(8), .CONFLICT_POLICY(0), .RESET_VAL(8'h00)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q0), .q_n(qn0), .conflict(cf0), .conflict_mask(mk0), .conflict_cnt(cnt0),
    .conflict_sticky(st0));
  sr_reg_bank #(.WIDTH(8), .CNT_W(8), .CONFLICT_POLICY(1), .RESET_VAL(8'h3C)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q1), .q_n(qn1), .conflict(cf1), .conflict_mask(mk1), .conflict_cnt(cnt1),
    .conflict_sticky(st1));
  sr_reg_bank #(.WIDTH(8), .CNT_W(8), .CONFLICT_POLICY(2), .RESET_VAL(8'h00)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q2), .q_n(qn2), .conflict(cf2), .conflict_mask(mk2), .conflict_cnt(cnt2),
    .conflict_sticky(st2));
  sr_reg_bank #(.WIDTH(8), .CNT_W(2), .CONFLICT_POLICY(0), .RESET_VAL(8'h00)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r), .clr_err(clr_err),
    .q(q3), .q_n(qn3), .conflict(cf3), .conflict_mask(mk3), .conflict_cnt(cnt3),
    .conflict_sticky(st3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pol_of(int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction

  function automatic logic [7:0] rst_of(int i);
    return (i == 1) ? 8'h3C : 8'h00;
  endfunction

  function automatic logic [7:0] cmax_of(int i);
    return (i == 3) ? 8'd3 : 8'd255;
  endfunction

  // Vector-wide reference for one edge.
  function automatic logic [7:0] m_next(logic [7:0] q, logic [7:0] sv, logic [7:0] rv,
                                        logic [1:0] md, int pol);
    logic [7:0] setb, clrb, both, res;
    setb = sv & ~rv;
    clrb = rv & ~sv;
    both = sv & rv;
    res  = (q & ~clrb) | setb;
    case (md)
      2'b00: begin
        if (pol == 1)      res = res | both;
        else if (pol == 2) res = res & ~both;
      end
      2'b01:   res = res ^ both;
      2'b10:   res = sv;
      default: res = q ^ sv;
    endcase
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i]   = rst_of(i);
      mcnt[i] = 8'd0;
    end
    mst = 1'b0;
    exp_q.delete();
  endtask

  // Compute the expected post-edge state, queue it, then apply the stimulus
  // and advance one edge. Returns at posedge+1.
  task automatic drive(input logic e_en, input logic [1:0] md, input logic [7:0] sv,
                       input logic [7:0] rv, input logic c);
    exp_t x;
    logic cf;
    cf = e_en && (md == 2'b00) && ((sv & rv) != 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (e_en) mq[i] = m_next(mq[i], sv, rv, md, pol_of(i));
      if (cf) mcnt[i] = c ? 8'd1 : ((mcnt[i] == cmax_of(i)) ? mcnt[i] : mcnt[i] + 8'd1);
      else if (c) mcnt[i] = 8'd0;
      x.q[i]   = mq[i];
      x.cnt[i] = mcnt[i];
    end
    if (cf) mst = 1'b1;
    else if (c) mst = 1'b0;
    x.conflict = cf;
    x.mask     = cf ? (sv & rv) : 8'h00;
    x.sticky   = mst;
    exp_q.push_back(x);
    en = e_en; mode = md; s = sv; r = rv; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    checks++; if (q0 !== 8'h00 || q1 !== 8'h3C) begin errors++;
      $display("FAIL reset_init q0=%h q1=%h want 00 3c", q0, q1); end
    drive(1'b1, 2'b10, 8'hA5, 8'h00, 1'b0);
    x = exp_q.pop_front();
    checks++; if (q0 !== x.q[0]) begin errors++;
      $display("FAIL reset_load q0=%h want %h", q0, x.q[0]); end
    drive(1'b1, 2'b00, 8'h01, 8'h01, 1'b0);
    x = exp_q.pop_front();
    checks++; if (q0 !== x.q[0] || cf0 !== x.conflict || cnt0 !== x.cnt[0]) begin errors++;
      $display("FAIL reset_pre q0=%h cf=%b cnt=%h want %h %b %h",
               q0, cf0, cnt0, x.q[0], x.conflict, x.cnt[0]); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (q0 !== 8'h00 || q1 !== 8'h3C || qn0 !== 8'hFF || qn1 !== 8'hC3) begin errors++;
      $display("FAIL reset_async_q q0=%h q1=%h qn0=%h qn1=%h want 00 3c ff c3", q0, q1, qn0, qn1); end
    checks++; if (cf0 !== 1'b0 || mk0 !== 8'h00 || cnt0 !== 8'h00 || st0 !== 1'b0 ||
                  cnt3 !== 2'd0 || st3 !== 1'b0) begin errors++;
      $display("FAIL reset_async_status cf=%b mk=%h cnt=%h st=%b cnt3=%h st3=%b want zeros",
               cf0, mk0, cnt0, st0, cnt3, st3); end
    #2;
    rst_n = 1'b1;
    drive(1'b1, 2'b10, 8'h5A, 8'h00, 1'b0);
    x = exp_q.pop_front();
    checks++; if (q0 !== x.q[0] || q1 !== x.q[1]) begin errors++;
      $display("FAIL reset_first_edge q0=%h q1=%h want %h %h", q0, q1, x.q[0], x.q[1]); end
  endtask

  task automatic test_sr_basic();
    exp_t x;
    drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b1, 2'b00, 8'h0F, 8'hF0, 1'b0);
    x = exp_q.pop_front();
    checks++; if (q0 !== x.q[0] || q0 !== 8'h0F || cf0 !== 1'b0) begin errors++;
      $display("FAIL sr_set q0=%h cf=%b want %h 0", q0, cf0, x.q[0]); end
    drive(1'b1, 2'b00, 8'h00, 8'h03, 1'b0);
    x = exp_q.pop_front();
    checks++; if (q0 !== x.q[0] || q0 !== 8'h0C || qn0 !== ~x.q[0] || cf0 !== 1'b0) begin errors++;
      $display("FAIL sr_clear q0=%h qn0=%h cf=%b want %h", q0, qn0, cf0, x.q[0]); end
  endtask

  task automatic test_policy();
    exp_t x;
    drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b1);
    void'(exp_q.pop_front());
    drive(1'b1, 2'b00, 8'h01, 8'h01, 1'b0);
    x = exp_q.pop_front();
    checks++; if (q0 !== x.q[0] || q1 !== x.q[1] || q2 !== x.q[2]) begin errors++;
      $display("FAIL policy_q q=%h/%h/%h want %h/%h/%h", q0, q1, q2, x.q[0], x.q[1], x.q[2]); end
    checks++; if (cf0 !== 1'b1 || cf1 !== 1'b1 || cf2 !== 1'b1 || mk0 !== x.mask || mk1 !== x.mask) begin errors++;
      $display("FAIL policy_pulse cf=%b%b%b mk=%h want 111 %h", cf0, cf1, cf2, mk0, x.mask); end
    checks++; if (cnt0 !== x.cnt[0] || cnt2 !== x.cnt[2] || st0 !== x.sticky || st2 !== x.sticky) begin errors++;
      $display("FAIL policy_cnt cnt=%h st=%b want %h %b", cnt0, st0, x.cnt[0], x.sticky); end
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    x = exp_q.pop_front();
    checks++; if (cf0 !== 1'b0 || mk0 !== 8'h00 || cnt0 !== x.cnt[0] || st0 !== 1'b1) begin errors++;
      $display("FAIL policy_after cf=%b mk=%h cnt=%h st=%b want 0 00 %h 1", cf0, mk0, cnt0, st0, x.cnt[0]); end
  endtask

  task automatic test_jk_t();
    exp_t x;
    drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0);
      x = exp_q.pop_front();
      checks++; if (q0 !== x.q[0] || cf0 !== 1'b0) begin errors++;
        $display("FAIL jk_toggle%0d q0=%h cf=%b want %h 0", k, q0, cf0, x.q[0]); end
    end
    drive(1'b1, 2'b11, 8'h81, 8'h00, 1'b0);
    x = exp_q.pop_front();
    checks++; if (q0 !== x.q[0] || q0 !== 8'h7E) begin errors++;
      $display("FAIL t_toggle q0=%h want %h", q0, x.q[0]); end
  endtask

  task automatic test_saturate();
    exp_t x;
    drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b1);
    void'(exp_q.pop_front());
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b00, 8'h03, 8'h06, 1'b0);
      x = exp_q.pop_front();
      checks++; if (cnt3 !== x.cnt[3][1:0] || cnt0 !== x.cnt[0] || mk3 !== x.mask) begin errors++;
        $display("FAIL sat_cnt%0d cnt3=%0d cnt0=%0d mk3=%h want %0d %0d %h",
                 k, cnt3, cnt0, mk3, x.cnt[3], x.cnt[0], x.mask); end
    end
    drive(1'b1, 2'b00, 8'h10, 8'h10, 1'b1);
    x = exp_q.pop_front();
    checks++; if (cnt3 !== 2'd1 || cnt0 !== x.cnt[0] || st3 !== 1'b1 || cf3 !== 1'b1) begin errors++;
      $display("FAIL clr_with_conflict cnt3=%0d cnt0=%0d st=%b cf=%b want 1 %0d 1 1", cnt3, cnt0, st3, cf3, x.cnt[0]); end
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    x = exp_q.pop_front();
    checks++; if (cnt3 !== 2'd0 || cnt0 !== x.cnt[0] || st3 !== 1'b0 || cf3 !== 1'b0) begin errors++;
      $display("FAIL clr_alone cnt3=%0d cnt0=%0d st=%b cf=%b want 0 %0d 0 0", cnt3, cnt0, st3, cf3, x.cnt[0]); end
  endtask

  task automatic test_enable();
    exp_t x;
    drive(1'b1, 2'b00, 8'h01, 8'h01, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b0, 2'b10, 8'hFF, 8'h00, 1'b0);
    x = exp_q.pop_front();
    checks++; if (q0 !== x.q[0] || q1 !== x.q[1] || cf0 !== 1'b0) begin errors++;
      $display("FAIL en0_d q0=%h q1=%h cf=%b want %h %h 0", q0, q1, cf0, x.q[0], x.q[1]); end
    drive(1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0);
    x = exp_q.pop_front();
    checks++; if (cf0 !== 1'b0 || mk0 !== 8'h00 || cnt0 !== x.cnt[0] || st0 !== x.sticky) begin errors++;
      $display("FAIL en0_sr cf=%b mk=%h cnt=%h st=%b want 0 00 %h %b", cf0, mk0, cnt0, st0, x.cnt[0], x.sticky); end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int k = 0; k < 40; k++) begin
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            8'($urandom & $urandom), ($urandom_range(0, 9) == 0));
      x = exp_q.pop_front();
      checks++; if (q0 !== x.q[0] || q1 !== x.q[1] || q2 !== x.q[2] || q3 !== x.q[3] ||
                    qn2 !== ~x.q[2] || qn3 !== ~x.q[3]) begin errors++;
        $display("FAIL b2b_q%0d q=%h/%h/%h/%h want %h/%h/%h/%h",
                 k, q0, q1, q2, q3, x.q[0], x.q[1], x.q[2], x.q[3]); end
      checks++; if (cf0 !== x.conflict || cf2 !== x.conflict || mk0 !== x.mask || mk2 !== x.mask ||
                    cnt0 !== x.cnt[0] || cnt1 !== x.cnt[1] || cnt3 !== x.cnt[3][1:0] ||
                    st0 !== x.sticky || st1 !== x.sticky || st2 !== x.sticky) begin errors++;
        $display("FAIL b2b_status%0d cf=%b mk=%h cnt0=%0d cnt3=%0d st=%b want %b %h %0d %0d %b",
                 k, cf0, mk0, cnt0, cnt3, st0, x.conflict, x.mask, x.cnt[0], x.cnt[3], x.sticky); end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; s = 8'h00; r = 8'h00; clr_err = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_sr_basic();
    test_policy();
    test_jk_t();
    test_saturate();
    test_enable();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
